// File: rtl/noc_sink_checker_pe.sv
// noc_sink_checker_pe
// Ejection-side sink for one mesh node. Accepts flits from the NoC under an
// LFSR-driven backpressure pattern, verifies the destination and the
// per-source sequence numbering, and keeps saturating statistics counters.
// Flow: a one-flit capture register feeds a fully pipelined check stage.

module noc_sink_checker_pe #(
  parameter int         xcord       = 0,
  parameter int         ycord       = 0,
  parameter int         X           = 2,
  parameter int         Y           = 2,
  parameter int         x_size      = 1,
  parameter int         y_size      = 1,
  parameter int         data_width  = 256,
  parameter int         total_width = x_size + y_size + data_width,
  parameter int         expPkts     = 300,
  parameter int         stallRate   = 0,
  parameter logic [7:0] seed        = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   i_valid,
  input  logic [total_width-1:0] i_data,
  output logic                   o_ready,
  output logic                   done,
  output logic [31:0]            rcvCount,
  output logic [31:0]            misrouteCount,
  output logic [31:0]            seqErrCount,
  output logic                   error
);

  localparam int              nodes    = X * Y;
  localparam int              idx_w    = (nodes > 1) ? $clog2(nodes) : 1;
  localparam int              src_w    = x_size + y_size;
  localparam logic [x_size-1:0] my_x   = x_size'(xcord);
  localparam logic [y_size-1:0] my_y   = y_size'(ycord);
  localparam logic [8:0]      stall_th = 9'(stallRate);
  localparam logic [31:0]     last_cnt = 32'(expPkts - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t     state;
  logic [7:0] lfsr;
  logic [7:0] lfsr_next;

  // Flit field extraction
  logic [data_width-1:0] payload;
  logic [x_size-1:0]     in_dest_x;
  logic [y_size-1:0]     in_dest_y;
  logic [x_size-1:0]     in_src_x;
  logic [y_size-1:0]     in_src_y;
  logic [31:0]           in_seq;

  assign payload   = i_data[total_width-1 -: data_width];
  assign in_dest_x = i_data[x_size-1:0];
  assign in_dest_y = i_data[x_size +: y_size];
  assign in_src_x  = payload[x_size-1:0];
  assign in_src_y  = payload[x_size +: y_size];
  assign in_seq    = payload[src_w +: 32];

  // Payload bits above the sequence number carry no meaning for the sink.
  if (data_width > src_w + 32) begin : g_unused
    logic unused_payload;
    assign unused_payload = ^payload[data_width-1:src_w+32];
  end

  // Capture stage
  logic              cap_valid;
  logic [x_size-1:0] cap_dest_x;
  logic [y_size-1:0] cap_dest_y;
  logic [x_size-1:0] cap_src_x;
  logic [y_size-1:0] cap_src_y;
  logic [31:0]       cap_seq;

  // Check stage
  logic [31:0]      exp_tab [nodes];
  logic [31:0]      src_idx;
  logic [idx_w-1:0] tab_idx;
  logic             src_ok;
  logic [31:0]      exp_rd;
  logic             seq_bad;
  logic             misroute;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Sink accepts only while running; the drain phase never stalls.
  assign o_ready = (state == ST_DONE) ||
                   ((state == ST_RUN) && ({1'b0, lfsr} >= stall_th));

  // x^8 + x^6 + x^5 + x^4 + 1, shifting left.
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // Control FSM: IDLE until start, RUN until the expected total is counted,
  // then DONE (sticky) where counting continues.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      lfsr  <= seed;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_RUN;
        end
        ST_RUN: begin
          lfsr <= lfsr_next;
          if (cap_valid && (rcvCount == last_cnt)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture valid: a reset drops any flit already taken but not yet checked.
  always_ff @(posedge clk) begin
    if (rst) cap_valid <= 1'b0;
    else     cap_valid <= i_valid & o_ready;
  end

  // Capture the fields of an accepted flit.
  // NOTE: pure datapath registers are qualified by cap_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (i_valid && o_ready) begin
      cap_dest_x <= in_dest_x;
      cap_dest_y <= in_dest_y;
      cap_src_x  <= in_src_x;
      cap_src_y  <= in_src_y;
      cap_seq    <= in_seq;
    end
  end

  // Check-stage decode. The table is read combinationally and written at the
  // end of the same cycle, so a same-source flit in the very next cycle
  // already sees the updated expectation without a separate bypass path.
  assign src_idx  = 32'(cap_src_x) + 32'(X) * 32'(cap_src_y);
  assign src_ok   = (src_idx < 32'(nodes));
  assign tab_idx  = src_idx[idx_w-1:0];
  assign exp_rd   = src_ok ? exp_tab[tab_idx] : 32'd0;
  assign seq_bad  = !src_ok || (cap_seq != exp_rd);
  assign misroute = (cap_dest_x != my_x) || (cap_dest_y != my_y);

  // Check stage: update counters, sticky error and the expected-sequence table.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcvCount      <= 32'd0;
      misrouteCount <= 32'd0;
      seqErrCount   <= 32'd0;
      error         <= 1'b0;
      // NOTE: the sequence table must restart from zero after every reset,
      // so unlike a plain RAM it is explicitly cleared here.
      for (int i = 0; i < nodes; i++) exp_tab[i] <= 32'd0;
    end else if (cap_valid) begin
      rcvCount <= sat_inc(rcvCount);
      if (misroute) begin
        misrouteCount <= sat_inc(misrouteCount);
        error         <= 1'b1;
      end
      if (seq_bad) begin
        seqErrCount <= sat_inc(seqErrCount);
        error       <= 1'b1;
      end
      if (src_ok) exp_tab[tab_idx] <= cap_seq + 32'd1;
    end
  end

endmodule

// File: tb/tb_noc_sink_checker_pe.sv
// Self-checking bench for noc_sink_checker_pe. A vector table drives flits;
// each accepted flit pushes its expected counter snapshot to a scoreboard
// that is compared once the check stage has had its edge.

module tb_noc_sink_checker_pe;

  localparam int DW = 64;
  localparam int TW = DW + 2;

  typedef struct {
    string       name;
    int          dut;
    int          due;
    logic [31:0] rcv;
    logic [31:0] mis;
    logic [31:0] se;
    logic        err;
    logic        done;
  } exp_t;

  typedef struct {
    logic        fresh;
    logic        sx;
    logic        sy;
    logic        dx;
    logic        dy;
    logic [31:0] seq;
    logic [31:0] rcv;
    logic [31:0] mis;
    logic [31:0] se;
    logic        err;
    logic        done;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [1:0]    st;
  logic [1:0]    vld;
  logic [TW-1:0] dat [2];
  wire  [1:0]    rdy;
  wire  [1:0]    dn;
  wire  [1:0]    er;
  wire  [31:0]   rcv_c [2];
  wire  [31:0]   mis_c [2];
  wire  [31:0]   se_c  [2];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   stalls   = 0;
  exp_t sb_q[$];
  vec_t vt[$];

  noc_sink_checker_pe #(
    .xcord(0), .ycord(0), .X(2), .Y(2), .x_size(1), .y_size(1),
    .data_width(DW), .expPkts(8), .stallRate(0), .seed(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start(st[0]), .i_valid(vld[0]), .i_data(dat[0]),
    .o_ready(rdy[0]), .done(dn[0]), .rcvCount(rcv_c[0]),
    .misrouteCount(mis_c[0]), .seqErrCount(se_c[0]), .error(er[0])
  );

  noc_sink_checker_pe #(
    .xcord(0), .ycord(0), .X(2), .Y(2), .x_size(1), .y_size(1),
    .data_width(DW), .expPkts(300), .stallRate(128), .seed(8'hA5)
  ) dut_stall (
    .clk(clk), .rst(rst), .start(st[1]), .i_valid(vld[1]), .i_data(dat[1]),
    .o_ready(rdy[1]), .done(dn[1]), .rcvCount(rcv_c[1]),
    .misrouteCount(mis_c[1]), .seqErrCount(se_c[1]), .error(er[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: compare each accepted flit's expectation after its check edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check({e.name, " rcvCount"},      rcv_c[e.dut], e.rcv);
      check({e.name, " misrouteCount"}, mis_c[e.dut], e.mis);
      check({e.name, " seqErrCount"},   se_c[e.dut],  e.se);
      check({e.name, " error"},         32'(er[e.dut]), 32'(e.err));
      check({e.name, " done"},          32'(dn[e.dut]), 32'(e.done));
    end
  end

  function automatic vec_t mk(input int fresh, input int sx, input int sy,
                              input int dx, input int dy, input logic [31:0] seq,
                              input int rcv, input int mis, input int se,
                              input int err, input int done);
    vec_t v;
    v.fresh = (fresh != 0);
    v.sx    = (sx != 0);
    v.sy    = (sy != 0);
    v.dx    = (dx != 0);
    v.dy    = (dy != 0);
    v.seq   = seq;
    v.rcv   = 32'(rcv);
    v.mis   = 32'(mis);
    v.se    = 32'(se);
    v.err   = (err != 0);
    v.done  = (done != 0);
    return v;
  endfunction

  function automatic logic [TW-1:0] mk_flit(input logic sx, input logic sy,
                                            input logic dx, input logic dy,
                                            input logic [31:0] seq);
    logic [DW-1:0] p;
    p          = '0;
    p[0]       = sx;
    p[1]       = sy;
    p[33:2]    = seq;
    p[DW-1:34] = 30'($urandom);
    return {p, dy, dx};
  endfunction

  // Called at a negedge: present the flit and hold it until o_ready lets it in.
  task automatic send(input int d, input logic [TW-1:0] flit, input exp_t e);
    vld[d] = 1'b1;
    dat[d] = flit;
    for (int t = 0; t < 64; t++) begin
      if (rdy[d]) begin
        e.dut = d;
        e.due = cyc + 2;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        return;
      end
      stalls++;
      @(posedge clk);
      @(negedge clk);
    end
    check({e.name, " accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    vld = '0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = '0;
    st  = '0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start(input int d);
    st[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   ones;
    rst    = 1'b1;
    st     = '0;
    vld    = '0;
    dat[0] = '0;
    dat[1] = '0;

    // fresh, src x/y, dest x/y, seq, expected rcv/mis/seqerr/error/done
    vt.push_back(mk(1, 1, 0, 0, 0, 32'd0, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 32'd1, 2, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 32'd2, 3, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 32'd3, 4, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, 1, 32'd0, 1, 1, 0, 1, 0));
    vt.push_back(mk(1, 1, 1, 0, 0, 32'd0, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 0, 0, 32'd1, 2, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 0, 0, 32'd3, 3, 0, 1, 1, 0));
    vt.push_back(mk(0, 1, 1, 0, 0, 32'd4, 4, 0, 1, 1, 0));
    vt.push_back(mk(0, 1, 1, 0, 0, 32'd5, 5, 0, 1, 1, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 32'd0, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 32'd0, 2, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 32'd1, 3, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 32'd1, 4, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 32'd2, 5, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 32'd2, 6, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 32'd3, 7, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 32'd3, 8, 0, 0, 0, 1));
    vt.push_back(mk(0, 1, 0, 0, 0, 32'd4, 9, 0, 0, 0, 1));
    vt.push_back(mk(1, 0, 1, 0, 0, 32'hFFFF_FFFF, 1, 0, 1, 1, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 32'd0, 2, 0, 1, 1, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 32'd1, 3, 0, 1, 1, 0));

    @(negedge clk);
    do_reset();
    check("reset rcvCount",      rcv_c[0], 32'd0);
    check("reset misrouteCount", mis_c[0], 32'd0);
    check("reset seqErrCount",   se_c[0],  32'd0);
    check("reset error",         32'(er[0]),  32'd0);
    check("reset done",          32'(dn[0]),  32'd0);
    check("reset o_ready",       32'(rdy[0]), 32'd0);
    idle(3);
    check("idle o_ready",        32'(rdy[0]), 32'd0);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].fresh) begin
        if (i > 0) idle(3);
        do_reset();
        do_start(0);
        if (i == 0) check("run o_ready", 32'(rdy[0]), 32'd1);
      end
      e.name = $sformatf("vec%0d", i);
      e.rcv  = vt[i].rcv;
      e.mis  = vt[i].mis;
      e.se   = vt[i].se;
      e.err  = vt[i].err;
      e.done = vt[i].done;
      send(0, mk_flit(vt[i].sx, vt[i].sy, vt[i].dx, vt[i].dy, vt[i].seq), e);
      if (i == 0)  check("latency count not yet visible", rcv_c[0], 32'd0);
      if (i == 18) check("done o_ready", 32'(rdy[0]), 32'd1);
    end
    idle(3);

    // Reset one cycle after a handshake: the captured flit must vanish.
    do_reset();
    do_start(0);
    e.name = "inflight";
    e.rcv  = 32'd1;
    e.mis  = 32'd0;
    e.se   = 32'd0;
    e.err  = 1'b0;
    e.done = 1'b0;
    send(0, mk_flit(1'b1, 1'b0, 1'b0, 1'b0, 32'd0), e);
    rst = 1'b1;
    vld = '0;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("inflight rst rcvCount", rcv_c[0], 32'd0);
    check("inflight rst o_ready",  32'(rdy[0]), 32'd0);
    rst = 1'b0;
    idle(3);
    check("inflight post rcvCount", rcv_c[0], 32'd0);
    check("inflight post o_ready",  32'(rdy[0]), 32'd0);

    // Stalling sink: never ready before start, no loss or duplication after.
    ones = 0;
    for (int t = 0; t < 4; t++) begin
      if (rdy[1]) ones++;
      idle(1);
    end
    check("stall idle o_ready", 32'(ones), 32'd0);
    do_start(1);
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      e.name = $sformatf("stall%0d", k);
      e.rcv  = 32'(k + 1);
      e.mis  = 32'd0;
      e.se   = 32'd0;
      e.err  = 1'b0;
      e.done = 1'b0;
      send(1, mk_flit(1'b1, 1'b0, 1'b0, 1'b0, 32'(k)), e);
    end
    idle(4);
    check("stall final rcvCount", rcv_c[1], 32'd40);
    check("stall ratio", 32'((stalls >= 12) && (stalls <= 100)), 32'd1);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
